// File: rtl/muldiv_stall_sequencer.sv
// Sequencer for the shared iterative HI/LO multiply/divide unit and the ID-stage stalls around it.
// Build option: define DIV0_FAST_EN to let a divide by zero skip the iteration and finish in one cycle.
module muldiv_stall_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_md_start,
    input  logic [1:0] ex_md_op,
    input  logic       ex_divisor_zero,
    input  logic       id_reads_hilo,
    input  logic       id_md_op,
    output logic       md_start,
    output logic       md_busy,
    output logic       hilo_we,
    output logic       PC_WriteEn,
    output logic       IFID_WriteEn,
    output logic       Stall_flush,
    output logic       div0_flag,
    output logic       md_overlap_err
);

    // state  | meaning
    // IDLE   | unit free, waiting for a mult/div in EX
    // RUN    | unit iterating, cnt counts down to terminal count 0
    // DONE   | result ready, hilo_we high; may accept a back-to-back issue

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             fast_div0;
    logic             stall;
    logic             hilo_we_r;
    logic             overlap_err_r;

    assign accept = ex_md_start && (state == S_IDLE || state == S_DONE);

`ifdef DIV0_FAST_EN
    logic div0_r;

    assign fast_div0 = accept && ex_md_op[1] && ex_divisor_zero;
    assign div0_flag = div0_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div0_r <= 1'b0;
        end else begin
            div0_r <= fast_div0;
        end
    end
`else
    logic div0_unused;

    assign div0_unused = ex_divisor_zero;
    assign fast_div0   = 1'b0;
    assign div0_flag   = 1'b0;
`endif

    // hilo_we is registered from the next state so it tracks state==DONE exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            hilo_we_r     <= 1'b0;
            overlap_err_r <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hilo_we_r     <= (state_nxt == S_DONE);
            overlap_err_r <= overlap_err_r | (state == S_RUN && ex_md_start);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (fast_div0) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_RUN;
                        cnt_nxt   = ex_md_op[1] ? DIV_LOAD : MUL_LOAD;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // DONE alone does not stall: the dependent instruction reaches EX after HI/LO is written.
    always_comb begin
        md_start       = accept;
        md_busy        = (state == S_RUN) || (state == S_DONE);
        stall          = ((state == S_RUN) || accept) && (id_reads_hilo || id_md_op);
        PC_WriteEn     = ~stall;
        IFID_WriteEn   = ~stall;
        Stall_flush    = stall;
        hilo_we        = hilo_we_r;
        md_overlap_err = overlap_err_r;
    end

endmodule

// File: tb/tb_muldiv_stall_sequencer.sv
// Directed bench for muldiv_stall_sequencer: per-cycle vector table plus long multi-cycle sequences.
// Expectations for the divide-by-zero case follow DIV0_FAST_EN when it is defined.
module tb_muldiv_stall_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ex_md_start;
    logic [1:0] ex_md_op;
    logic       ex_divisor_zero;
    logic       id_reads_hilo;
    logic       id_md_op;
    logic       md_start;
    logic       md_busy;
    logic       hilo_we;
    logic       PC_WriteEn;
    logic       IFID_WriteEn;
    logic       Stall_flush;
    logic       div0_flag;
    logic       md_overlap_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       r;
        bit       st;
        bit [1:0] op;
        bit       dz;
        bit       rh;
        bit       mo;
        bit       e_start;
        bit       e_busy;
        bit       e_hilo;
        bit       e_stall;
        bit       e_div0;
        bit       e_err;
        bit       chk;
    } vec_t;

    vec_t vq[$];

    muldiv_stall_sequencer #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ex_md_start(ex_md_start),
        .ex_md_op(ex_md_op),
        .ex_divisor_zero(ex_divisor_zero),
        .id_reads_hilo(id_reads_hilo),
        .id_md_op(id_md_op),
        .md_start(md_start),
        .md_busy(md_busy),
        .hilo_we(hilo_we),
        .PC_WriteEn(PC_WriteEn),
        .IFID_WriteEn(IFID_WriteEn),
        .Stall_flush(Stall_flush),
        .div0_flag(div0_flag),
        .md_overlap_err(md_overlap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input bit r, input bit st, input bit [1:0] op, input bit dz,
                       input bit rh, input bit mo, input bit es, input bit eb,
                       input bit eh, input bit esl, input bit ed, input bit ee, input bit c);
        vec_t v;
        v = '{r, st, op, dz, rh, mo, es, eb, eh, esl, ed, ee, c};
        vq.push_back(v);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit es, input bit eb, input bit eh,
                             input bit esl, input bit ed, input bit ee);
        chk1({tag, ".md_start"},       md_start,       es);
        chk1({tag, ".md_busy"},        md_busy,        eb);
        chk1({tag, ".hilo_we"},        hilo_we,        eh);
        chk1({tag, ".PC_WriteEn"},     PC_WriteEn,     ~esl);
        chk1({tag, ".IFID_WriteEn"},   IFID_WriteEn,   ~esl);
        chk1({tag, ".Stall_flush"},    Stall_flush,    esl);
        chk1({tag, ".div0_flag"},      div0_flag,      ed);
        chk1({tag, ".md_overlap_err"}, md_overlap_err, ee);
    endtask

    // One clock cycle: drive just after the rising edge, sample mid-cycle.
    task automatic run_cycle(input bit r, input bit st, input bit [1:0] op, input bit dz,
                             input bit rh, input bit mo, input string tag, input bit c,
                             input bit es, input bit eb, input bit eh, input bit esl,
                             input bit ed, input bit ee);
        @(posedge clk);
        #1;
        rst_n           = r;
        ex_md_start     = st;
        ex_md_op        = op;
        ex_divisor_zero = dz;
        id_reads_hilo   = rh;
        id_md_op        = mo;
        #4;
        if (c) check_all(tag, es, eb, eh, esl, ed, ee);
    endtask

    initial begin
        rst_n           = 1'b0;
        ex_md_start     = 1'b0;
        ex_md_op        = 2'b00;
        ex_divisor_zero = 1'b0;
        id_reads_hilo   = 1'b0;
        id_md_op        = 1'b0;

        //  r st op    dz rh mo | start busy hilo stall div0 err | chk
        add(0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0);  // reset cycle 1
        add(0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0);  // reset cycle 2
        add(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1);  // released
        add(1, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0,  1);  // MFHI in ID, unit idle
        // MULT with dependent MFHI held in ID
        add(1, 1, 2'b00, 0, 1, 0,  1, 0, 0, 1, 0, 0,  1);  // c0 accept + stall
        add(1, 0, 2'b00, 0, 1, 0,  0, 1, 0, 1, 0, 0,  1);  // c1
        add(1, 0, 2'b00, 0, 1, 0,  0, 1, 0, 1, 0, 0,  1);  // c2
        add(1, 0, 2'b00, 0, 1, 0,  0, 1, 0, 1, 0, 0,  1);  // c3
        add(1, 0, 2'b00, 0, 1, 0,  0, 1, 0, 1, 0, 0,  1);  // c4
        add(1, 0, 2'b00, 0, 1, 0,  0, 1, 1, 0, 0, 0,  1);  // c5 DONE, released
        add(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1);  // c6 idle
        // MULTU with mult/div in ID, then an overlapping start during RUN
        add(1, 1, 2'b01, 0, 0, 1,  1, 0, 0, 1, 0, 0,  1);  // c0
        add(1, 0, 2'b00, 0, 0, 0,  0, 1, 0, 0, 0, 0,  1);  // c1
        add(1, 1, 2'b10, 0, 0, 0,  0, 1, 0, 0, 0, 0,  1);  // c2 overlap ignored
        add(1, 0, 2'b00, 0, 0, 0,  0, 1, 0, 0, 0, 1,  1);  // c3 err sticky
        add(1, 0, 2'b00, 0, 0, 1,  0, 1, 0, 1, 0, 1,  1);  // c4 RUN stall via id_md_op
        add(1, 0, 2'b00, 0, 0, 0,  0, 1, 1, 0, 0, 1,  1);  // c5 DONE on original schedule
        add(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 1,  1);  // c6
        // Reset in the middle of RUN
        add(1, 1, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0, 1,  1);  // c0
        add(1, 0, 2'b00, 0, 0, 0,  0, 1, 0, 0, 0, 1,  1);  // c1
        add(0, 0, 2'b00, 0, 0, 0,  0, 1, 0, 0, 0, 1,  1);  // c2 reset asserted
        add(1, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0,  1);  // c3 idle, err cleared
        add(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1);  // c4
        add(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1);  // c5 no aborted hilo_we
        add(1, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1);  // c6

        foreach (vq[i]) begin
            run_cycle(vq[i].r, vq[i].st, vq[i].op, vq[i].dz, vq[i].rh, vq[i].mo,
                      $sformatf("vec%0d", i), vq[i].chk,
                      vq[i].e_start, vq[i].e_busy, vq[i].e_hilo, vq[i].e_stall,
                      vq[i].e_div0, vq[i].e_err);
        end

        // Back-to-back: DIVU, then MULT issued in the DONE cycle with MFHI in ID
        run_cycle(1, 1, 2'b11, 0, 0, 0, "b2b_c0", 1,  1, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 32; c++)
            run_cycle(1, 0, 2'b00, 0, 0, 0, $sformatf("b2b_c%0d", c), 1,  0, 1, 0, 0, 0, 0);
        run_cycle(1, 1, 2'b00, 0, 1, 0, "b2b_c33", 1,  1, 1, 1, 1, 0, 0);
        for (int c = 34; c <= 37; c++)
            run_cycle(1, 0, 2'b00, 0, 1, 0, $sformatf("b2b_c%0d", c), 1,  0, 1, 0, 1, 0, 0);
        run_cycle(1, 0, 2'b00, 0, 1, 0, "b2b_c38", 1,  0, 1, 1, 0, 0, 0);
        run_cycle(1, 0, 2'b00, 0, 0, 0, "b2b_c39", 1,  0, 0, 0, 0, 0, 0);

        // DIV with a zero divisor
        run_cycle(1, 1, 2'b10, 1, 0, 0, "div0_c0", 1,  1, 0, 0, 0, 0, 0);
`ifdef DIV0_FAST_EN
        run_cycle(1, 0, 2'b00, 0, 0, 0, "div0_c1", 1,  0, 1, 1, 0, 1, 0);
        run_cycle(1, 0, 2'b00, 0, 0, 0, "div0_c2", 1,  0, 0, 0, 0, 0, 0);
`else
        for (int c = 1; c <= 32; c++)
            run_cycle(1, 0, 2'b00, 0, 0, 0, $sformatf("div0_c%0d", c), 1,  0, 1, 0, 0, 0, 0);
        run_cycle(1, 0, 2'b00, 0, 0, 0, "div0_c33", 1,  0, 1, 1, 0, 0, 0);
        run_cycle(1, 0, 2'b00, 0, 0, 0, "div0_c34", 1,  0, 0, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
